// File: rtl/rstseq_pkg.sv
// Shared types and constant helpers for the reset/boot sequencer.
// No logic lives here; everything is elaboration-time.
package rstseq_pkg;

  typedef enum logic [2:0] {
    HARD     = 3'd0,
    SOFT     = 3'd1,
    WAIT_ROM = 3'd2,
    RUN      = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_HARD = 2'd1,
    CAUSE_DL   = 2'd2,
    CAUSE_CFG  = 2'd3
  } cause_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rstseq_debounce.sv
// Button conditioner: 2-FF synchroniser, then output follows only after DEBOUNCE_CYCLES stable samples.
// Latency 2 + DEBOUNCE_CYCLES cycles; no flow control. Built only with RSTSEQ_DEBOUNCE_EN.
module rstseq_debounce
  import rstseq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 57272
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_async_i,
  output logic btn_o
);

  localparam int DW = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // Counter tracks consecutive samples that disagree with the current output.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      stable_d = sync_q[1];
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn_async_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign btn_o = stable_q;

endmodule

// File: rtl/reset_sequencer.sv
// Orders POR, OSD, download and config-change events into hard/soft core resets; outputs 1 cycle after the event.
// No flow control; optional button debouncer with `RSTSEQ_DEBOUNCE_EN.
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int               CFG_W           = 4,
  parameter logic [CFG_W-1:0] CFG_MASK        = '1,
  parameter int               HARD_CYCLES     = 65536,
  parameter int               SOFT_CYCLES     = 16,
  parameter logic [7:0]       ROM_INDEX       = 8'd0,
  parameter int               REQUIRE_ROM     = 1,
  parameter int               DEBOUNCE_CYCLES = 57272
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CFG_W-1:0] cfg,
  input  logic             hard_req,
  input  logic             soft_req,
  input  logic             btn_req,
  input  logic             dl_active,
  input  logic [7:0]       dl_index,
  output logic             hard_reset,
  output logic             soft_reset,
  output logic             rom_loaded,
  output logic [2:0]       state,
  output logic [1:0]       cause
);

  localparam int CNT_W = clog2_min1(max_int(HARD_CYCLES, SOFT_CYCLES));
  localparam logic [CNT_W-1:0] HARD_LOAD = CNT_W'(HARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LOAD = CNT_W'(SOFT_CYCLES - 1);

  state_t           state_q, state_d;
  cause_t           cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hard_q, soft_q;
  logic             rom_q, rom_d;
  logic [CFG_W-1:0] cfg_q;
  logic             dl_q;
  logic [7:0]       idx_q;

  logic btn_s;
  logic cfg_chg, hard_ev, soft_ev;

`ifdef RSTSEQ_DEBOUNCE_EN
  rstseq_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .btn_async_i (btn_req),
    .btn_o       (btn_s)
  );
`else
  logic [1:0] btn_sync_q;
  logic       unused_debounce;

  // Debounce time is meaningless without the debouncer; fold it into a dead net.
  assign unused_debounce = ^32'(DEBOUNCE_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) btn_sync_q <= '0;
    else       btn_sync_q <= {btn_sync_q[0], btn_req};
  end

  assign btn_s = btn_sync_q[1];
`endif

  always_comb begin
    cfg_chg = |((cfg ^ cfg_q) & CFG_MASK);
    hard_ev = hard_req | dl_active | cfg_chg;
    soft_ev = soft_req | btn_s;

    // Fall of dl_active lands while HARD is still counting out, so the ROM is in before SOFT ends.
    rom_d = rom_q | (dl_q & ~dl_active & (idx_q == ROM_INDEX));

    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;

    if (hard_ev) begin
      state_d = HARD;
      cnt_d   = HARD_LOAD;
      if (dl_active)    cause_d = CAUSE_DL;
      else if (cfg_chg) cause_d = CAUSE_CFG;
      else              cause_d = CAUSE_HARD;
    end else begin
      case (state_q)
        HARD: begin
          if (cnt_q == '0) begin
            state_d = SOFT;
            cnt_d   = SOFT_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SOFT: begin
          if (soft_ev) begin
            cnt_d = SOFT_LOAD;
          end else if (cnt_q == '0) begin
            state_d = (rom_q || (REQUIRE_ROM == 0)) ? RUN : WAIT_ROM;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        WAIT_ROM: begin
          state_d = WAIT_ROM;
        end
        RUN: begin
          if (soft_ev) begin
            state_d = SOFT;
            cnt_d   = SOFT_LOAD;
          end
        end
        default: begin
          state_d = HARD;
          cnt_d   = HARD_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HARD;
      cnt_q   <= HARD_LOAD;
      cause_q <= CAUSE_POR;
      hard_q  <= 1'b1;
      soft_q  <= 1'b1;
      rom_q   <= 1'b0;
      cfg_q   <= cfg;
      dl_q    <= 1'b0;
      idx_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      hard_q  <= (state_d == HARD);
      soft_q  <= (state_d != RUN);
      rom_q   <= rom_d;
      cfg_q   <= cfg;
      dl_q    <= dl_active;
      if (dl_active) idx_q <= dl_index;
    end
  end

  assign hard_reset = hard_q;
  assign soft_reset = soft_q;
  assign rom_loaded = rom_q;
  assign state      = state_q;
  assign cause      = cause_q;

endmodule
